// File: rtl/stack_data_pkg.sv
// Shared command codes, bus width and occupancy helpers for the data stack.
// Latency: n/a (declarations only).
// Backpressure: n/a; full/empty are reported as flags, never as stalls.
package stack_data_pkg;

  // Data-stack command encoding driven by the controller.
  localparam int SC_N = 2;
  localparam logic [SC_N-1:0] SC_NON = 2'd0;
  localparam logic [SC_N-1:0] SC_PUS = 2'd1;
  localparam logic [SC_N-1:0] SC_POP = 2'd2;
  localparam logic [SC_N-1:0] SC_CLR = 2'd3;

  // Shared data bus width and its idle value.
  localparam int CD_N = 8;
  localparam logic [CD_N-1:0] CD_0 = '0;

  // Occupancy classes; implied purely by the stack pointer.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Classify a pointer value against the configured depth.
  function automatic occ_e occ_of(input int unsigned sp, input int unsigned depth);
    if (sp == 0)          return OCC_EMPTY;
    else if (sp >= depth) return OCC_FULL;
    else                  return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/stack_data_ram.sv
// Stack storage: DEPTH x W words, one synchronous write port, one async read port.
// Latency: write lands at the clock edge; read is combinational from the address.
// Backpressure: none; the caller guarantees writes only when space exists.
module stack_data_ram
  import stack_data_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = CD_N
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port: contents are never reset, only overwritten by pushes.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_data.sv
// LIFO data stack on a shared bidirectional bus; top of stack is presented when not pushing.
// Latency: zero-latency read of the top (POP reads and removes in one cycle); push visible next cycle.
// Backpressure: none; overflow/underflow are suppressed and raise the sticky dt_err flag.
module stack_data
  import stack_data_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [SC_N-1:0] dt_cmd,
  inout  wire  [CD_N-1:0] dt_data,
  output logic            dt_empty,
  output logic            dt_full,
  output logic            dt_err
);

  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] A_ONE   = AW'(1);

  logic [AW:0]     sp_q, sp_d;
  logic            err_q, err_d;
  logic            wr_en;
  logic [AW-1:0]   rd_addr;
  logic [CD_N-1:0] rd_dat;
  logic [CD_N-1:0] top_dat;
  logic            bus_oe;
  occ_e            occ;

  // Occupancy comes straight from the registered pointer; no separate state register.
  assign occ      = occ_of(int'(sp_q), DEPTH);
  assign dt_empty = (occ == OCC_EMPTY);
  assign dt_full  = (sp_q == SP_FULL);
  assign dt_err   = err_q;

  // Top entry lives at sp-1; the low AW bits wrap correctly when sp == DEPTH.
  assign rd_addr = sp_q[AW-1:0] - A_ONE;

  stack_data_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (CD_N)
  ) u_ram (
    .clk   (Clock),
    .we    (wr_en),
    .waddr (sp_q[AW-1:0]),
    .wdata (dt_data),
    .raddr (rd_addr),
    .rdata (rd_dat)
  );

  // Bus ownership: release the bus only while the controller pushes.
  assign bus_oe  = (dt_cmd != SC_PUS);
  assign top_dat = dt_empty ? CD_0 : rd_dat;
  assign dt_data = bus_oe ? top_dat : {CD_N{1'bz}};

  // Next-state for pointer and error flag; reset also blocks the memory write.
  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    wr_en = 1'b0;
    case (dt_cmd)
      SC_PUS: begin
        if (dt_full) begin
          err_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          sp_d  = sp_q + SP_ONE;
        end
      end
      SC_POP: begin
        if (dt_empty) begin
          err_d = 1'b1;
        end else begin
          sp_d = sp_q - SP_ONE;
        end
      end
      SC_CLR: begin
        sp_d  = '0;
        err_d = 1'b0;
      end
      default: begin
      end
    endcase
    if (!Reset) begin
      wr_en = 1'b0;
    end
  end

  // Pointer and sticky error register; reset wins over any command.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

endmodule
